// File: rtl/mopshub_sdo_pkg.sv
// Shared definitions for the MOPSHUB SDO transaction tracker: COB-ID ranges,
// frame field positions and the per-bus slot record.
package mopshub_sdo_pkg;

  localparam logic [11:0] SDO_TX_BASE = 12'h600;
  localparam logic [11:0] SDO_RX_BASE = 12'h580;

  // Frame layout: [75:64] = {1'b0, COB-ID}, [63:0] = data bytes, byte0 at top.
  localparam int COBID_HI = 75;
  localparam int COBID_LO = 64;
  localparam int NODE_HI  = 6;
  localparam int NODE_LO  = 0;
  localparam int MUX_HI   = 55;
  localparam int MUX_LO   = 32;

  typedef struct packed {
    logic        valid;
    logic [6:0]  node;
    logic [23:0] mux;
    logic [7:0]  age;
  } sdo_slot_t;

  function automatic logic is_sdo_req(input logic [11:0] cob);
    return (cob > SDO_TX_BASE) && (cob <= SDO_TX_BASE + 12'h07F);
  endfunction

  function automatic logic is_sdo_resp(input logic [11:0] cob);
    return (cob > SDO_RX_BASE) && (cob <= SDO_RX_BASE + 12'h07F);
  endfunction

endpackage

// File: rtl/sdo_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module sdo_tick_gen #(
  parameter int TICK_DIV = 40
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = wrap;

endmodule

// File: rtl/sdo_transaction_tracker.sv
// Pairs SDO requests on the downlink with responses on the uplink per CAN bus,
// reporting latency, timeouts, rejected requests and stray responses.
module sdo_transaction_tracker
  import mopshub_sdo_pkg::*;
#(
  parameter int N_BUSES       = 16,
  parameter int TICK_DIV      = 40,
  parameter int TIMEOUT_TICKS = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tra_valid,
  input  logic [75:0] data_tra_downlink,
  input  logic [4:0]  can_tra_select,
  input  logic        rec_valid,
  input  logic [75:0] data_rec_uplink,
  input  logic [4:0]  can_rec_select,
  output logic        resp_valid,
  output logic [4:0]  resp_bus,
  output logic [63:0] resp_data,
  output logic [7:0]  resp_latency,
  output logic        timeout_valid,
  output logic [4:0]  timeout_bus,
  output logic        req_reject,
  output logic        stray_resp,
  output logic [31:0] busy
);

  logic tick;

  sdo_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [11:0] tra_cob;
  logic [11:0] rec_cob;
  logic [23:0] tra_mux;
  logic [23:0] rec_mux;
  logic        tra_req;
  logic        rec_rsp;
  logic        rec_in_range;

  assign tra_cob      = data_tra_downlink[COBID_HI:COBID_LO];
  assign rec_cob      = data_rec_uplink[COBID_HI:COBID_LO];
  assign tra_mux      = data_tra_downlink[MUX_HI:MUX_LO];
  assign rec_mux      = data_rec_uplink[MUX_HI:MUX_LO];
  assign tra_req      = tra_valid && is_sdo_req(tra_cob);
  assign rec_rsp      = rec_valid && is_sdo_resp(rec_cob);
  assign rec_in_range = (32'(can_rec_select) < N_BUSES);

  logic [4:0] scan_q;
  logic [4:0] scan_d;

  logic [N_BUSES-1:0] match;
  logic [N_BUSES-1:0] expire;
  logic [N_BUSES-1:0] reject_v;
  logic [N_BUSES-1:0] valid_vec;
  logic [7:0]         lat_arr [N_BUSES];

  for (genvar gi = 0; gi < N_BUSES; gi++) begin : g_slot
    sdo_slot_t slot_q;
    sdo_slot_t slot_d;
    logic      req_sel;
    logic      rsp_sel;
    logic      hit;
    logic      exp_hit;
    logic      free;

    assign req_sel = tra_req && (can_tra_select == 5'(gi));
    assign rsp_sel = rec_rsp && (can_rec_select == 5'(gi));
    assign hit     = rsp_sel && slot_q.valid
                     && (slot_q.node == rec_cob[NODE_HI:NODE_LO])
                     && (slot_q.mux == rec_mux);
    // A matched response on the scanned slot takes precedence over expiry.
    assign exp_hit = (scan_q == 5'(gi)) && slot_q.valid
                     && (slot_q.age >= 8'(TIMEOUT_TICKS)) && !hit;
    assign free    = !slot_q.valid || hit || exp_hit;

    always_comb begin
      slot_d = slot_q;
      if (tick && slot_q.valid && (slot_q.age != 8'hFF)) begin
        slot_d.age = slot_q.age + 8'd1;
      end
      if (hit || exp_hit) begin
        slot_d = '0;
      end
      if (req_sel && free) begin
        slot_d.valid = 1'b1;
        slot_d.node  = tra_cob[NODE_HI:NODE_LO];
        slot_d.mux   = tra_mux;
        slot_d.age   = 8'd0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        slot_q <= '0;
      end else begin
        slot_q <= slot_d;
      end
    end

    assign match[gi]     = hit;
    assign expire[gi]    = exp_hit;
    assign reject_v[gi]  = req_sel && !free;
    assign valid_vec[gi] = slot_q.valid;
    assign lat_arr[gi]   = hit ? slot_q.age : 8'd0;
  end

  logic        resp_valid_q, resp_valid_d;
  logic [4:0]  resp_bus_q, resp_bus_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic [7:0]  resp_latency_q, resp_latency_d;
  logic        timeout_valid_q, timeout_valid_d;
  logic [4:0]  timeout_bus_q, timeout_bus_d;
  logic        req_reject_q, req_reject_d;
  logic        stray_resp_q, stray_resp_d;

  always_comb begin
    scan_d = (scan_q == 5'(N_BUSES - 1)) ? 5'd0 : scan_q + 5'd1;

    resp_valid_d   = |match;
    resp_bus_d     = resp_bus_q;
    resp_data_d    = resp_data_q;
    resp_latency_d = resp_latency_q;
    if (|match) begin
      resp_bus_d     = can_rec_select;
      resp_data_d    = data_rec_uplink[63:0];
      resp_latency_d = 8'd0;
      for (int i = 0; i < N_BUSES; i++) begin
        resp_latency_d = resp_latency_d | lat_arr[i];
      end
    end

    timeout_valid_d = |expire;
    timeout_bus_d   = (|expire) ? scan_q : timeout_bus_q;
    req_reject_d    = |reject_v;
    stray_resp_d    = rec_rsp && rec_in_range && !(|match);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q          <= '0;
      resp_valid_q    <= 1'b0;
      resp_bus_q      <= '0;
      resp_data_q     <= '0;
      resp_latency_q  <= '0;
      timeout_valid_q <= 1'b0;
      timeout_bus_q   <= '0;
      req_reject_q    <= 1'b0;
      stray_resp_q    <= 1'b0;
    end else begin
      scan_q          <= scan_d;
      resp_valid_q    <= resp_valid_d;
      resp_bus_q      <= resp_bus_d;
      resp_data_q     <= resp_data_d;
      resp_latency_q  <= resp_latency_d;
      timeout_valid_q <= timeout_valid_d;
      timeout_bus_q   <= timeout_bus_d;
      req_reject_q    <= req_reject_d;
      stray_resp_q    <= stray_resp_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_bus      = resp_bus_q;
  assign resp_data     = resp_data_q;
  assign resp_latency  = resp_latency_q;
  assign timeout_valid = timeout_valid_q;
  assign timeout_bus   = timeout_bus_q;
  assign req_reject    = req_reject_q;
  assign stray_resp    = stray_resp_q;
  assign busy          = 32'(valid_vec);

endmodule
